// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART Rx FIFO: sync hunt, LEN parse, payload forwarding, status.
// Define UART_RX_PKT_CSUM_EN to add a trailing checksum byte (LEN XOR payload).
module uart_rx_pkt_ctrl #(
    parameter int unsigned             FRAME_WIDTH    = 8,
    parameter logic [FRAME_WIDTH-1:0]  SYNC_BYTE      = FRAME_WIDTH'(8'hA5),
    parameter int unsigned             MAX_LEN        = 64,
    parameter int unsigned             TIMEOUT_CYCLES = 200000
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [FRAME_WIDTH+1:0] fifo_dout,
    output logic                   fifo_rd_en,
    output logic [FRAME_WIDTH-1:0] pl_data,
    output logic                   pl_valid,
    input  logic                   pl_ready,
    output logic                   pl_first,
    output logic                   pl_last,
    output logic                   pkt_done,
    output logic [2:0]             pkt_status,
    output logic                   busy
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FRAME_WIDTH-1:0] MAX_LEN_B = FRAME_WIDTH'(MAX_LEN);
    localparam logic [FRAME_WIDTH-1:0] ONE_B     = FRAME_WIDTH'(1);

    localparam logic [2:0] ST_OK   = 3'd0;
    localparam logic [2:0] ST_LINE = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
`ifdef UART_RX_PKT_CSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd3;
`endif
    localparam logic [2:0] ST_TMO  = 3'd4;

`ifdef UART_RX_PKT_CSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD} state_t;
`endif

    state_t                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   done_q, done_d;
    logic [2:0]             status_q, status_d;
`ifdef UART_RX_PKT_CSUM_EN
    logic [FRAME_WIDTH-1:0] acc_q, acc_d;
`endif

    logic [FRAME_WIDTH-1:0] head_data;
    logic                   head_err;

    assign head_data = fifo_dout[FRAME_WIDTH-1:0];
    assign head_err  = |fifo_dout[FRAME_WIDTH+1:FRAME_WIDTH];

    // Handshake outputs are forced low while reset is held so the FIFO is not drained.
    always_comb begin
        fifo_rd_en = 1'b0;
        pl_valid   = 1'b0;
        pl_data    = '0;
        pl_first   = 1'b0;
        pl_last    = 1'b0;
        if (reset) begin
            fifo_rd_en = !fifo_empty && ((state_q != S_PAYLOAD) || pl_ready);
            pl_valid   = (state_q == S_PAYLOAD) && !fifo_empty && !head_err;
            pl_data    = head_data;
            pl_first   = pl_valid && first_q;
            pl_last    = pl_valid && (cnt_q == ONE_B);
        end
    end

    assign pkt_done   = done_q;
    assign pkt_status = status_q;
    assign busy       = reset && (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        status_d = '0;
`ifdef UART_RX_PKT_CSUM_EN
        acc_d    = acc_q;
`endif
        if (state_q != S_IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fifo_rd_en) begin
            tmo_d = '0;
            if (head_err && (state_q != S_IDLE)) begin
                done_d   = 1'b1;
                status_d = ST_LINE;
                state_d  = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!head_err && (head_data == SYNC_BYTE)) begin
                            state_d = S_LEN;
                        end
                    end
                    S_LEN: begin
                        if ((head_data == '0) || (head_data > MAX_LEN_B)) begin
                            done_d   = 1'b1;
                            status_d = ST_LEN;
                            state_d  = S_IDLE;
                        end else begin
                            cnt_d   = head_data;
                            first_d = 1'b1;
`ifdef UART_RX_PKT_CSUM_EN
                            acc_d   = head_data;
`endif
                            state_d = S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        cnt_d   = cnt_q - 1'b1;
                        first_d = 1'b0;
`ifdef UART_RX_PKT_CSUM_EN
                        acc_d   = acc_q ^ head_data;
                        if (cnt_q == ONE_B) begin
                            state_d = S_CSUM;
                        end
`else
                        if (cnt_q == ONE_B) begin
                            done_d   = 1'b1;
                            status_d = ST_OK;
                            state_d  = S_IDLE;
                        end
`endif
                    end
`ifdef UART_RX_PKT_CSUM_EN
                    S_CSUM: begin
                        done_d   = 1'b1;
                        status_d = (head_data == acc_q) ? ST_OK : ST_CSUM;
                        state_d  = S_IDLE;
                    end
`endif
                    default: state_d = S_IDLE;
                endcase
            end
        end else if ((state_q != S_IDLE) && (tmo_q == TMO_LAST)) begin
            // A consume in the expiry cycle takes the branch above and restarts the count.
            done_d   = 1'b1;
            status_d = ST_TMO;
            state_d  = S_IDLE;
            tmo_d    = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            status_q <= '0;
`ifdef UART_RX_PKT_CSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            status_q <= status_d;
`ifdef UART_RX_PKT_CSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: byte-stream packet model plus per-cycle handshake checks.
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;
    localparam int unsigned FW   = 8;
    localparam int unsigned MAXL = 64;
    localparam int unsigned TMO  = 50;
`ifdef UART_RX_PKT_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam logic [FW+1:0] FE = 10'h100;
    localparam logic [FW+1:0] DE = 10'h200;

    typedef logic [FW+1:0] ent_q_t[$];
    typedef struct {
        logic [7:0] d;
        bit         first;
        bit         last;
    } pl_t;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [FW+1:0] fifo_dout = '0;
    logic          pl_ready = 1'b1;
    logic          fifo_rd_en, pl_valid, pl_first, pl_last, pkt_done, busy;
    logic [FW-1:0] pl_data;
    logic [2:0]    pkt_status;

    uart_rx_pkt_ctrl #(
        .FRAME_WIDTH(FW),
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(MAXL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .pl_data(pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .pl_first(pl_first),
        .pl_last(pl_last),
        .pkt_done(pkt_done),
        .pkt_status(pkt_status),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned last_pop_edge = 0;
    bit          toggle_ready = 1'b0;
    logic        rd_seen;
    ent_q_t      fifo_q;
    pl_t         exp_pl[$];
    int          exp_st[$];
    logic [7:0]  got_pl[$];
    int          got_st[$];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int gp(input int i);
        return (i < got_pl.size()) ? int'(got_pl[i]) : -1;
    endfunction

    function automatic int gs(input int i);
        return (i < got_st.size()) ? got_st[i] : -1;
    endfunction

    // First-word-fall-through FIFO model; pops on the rd_en seen before the edge.
    always begin
        @(negedge sys_clk);
        rd_seen = fifo_rd_en;
        @(posedge sys_clk);
        cyc++;
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        pl_ready   = toggle_ready ? ~pl_ready : 1'b1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    end

    always @(negedge sys_clk) begin
        if (reset) begin
            if (fifo_empty) begin
                check("rd_en_when_empty", int'(fifo_rd_en), 0);
                check("valid_when_empty", int'(pl_valid), 0);
            end else if (pl_ready) begin
                check("rd_en_when_ready", int'(fifo_rd_en), 1);
            end else if (pl_valid) begin
                check("rd_en_stall", int'(fifo_rd_en), 0);
            end
            if (!fifo_empty && fifo_dout[FW+1:FW] != 2'b00)
                check("err_byte_not_forwarded", int'(pl_valid), 0);
            if (pl_valid) begin
                check("pl_data_passthrough", int'(pl_data), int'(fifo_dout[FW-1:0]));
                if (pl_ready) begin
                    check("payload_expected", int'(exp_pl.size() > 0), 1);
                    if (exp_pl.size() > 0) begin
                        pl_t e;
                        e = exp_pl.pop_front();
                        check("pl_data", int'(pl_data), int'(e.d));
                        check("pl_first", int'(pl_first), int'(e.first));
                        check("pl_last", int'(pl_last), int'(e.last));
                    end
                    got_pl.push_back(pl_data);
                end
            end else begin
                check("pl_first_idle", int'(pl_first), 0);
                check("pl_last_idle", int'(pl_last), 0);
            end
            if (pkt_done) begin
                got_st.push_back(int'(pkt_status));
                check("status_expected", int'(exp_st.size() > 0), 1);
                if (exp_st.size() > 0) check("pkt_status", int'(pkt_status), exp_st.pop_front());
                if (pkt_status == 3'd4) check("timeout_latency", int'(cyc - last_pop_edge), TMO);
            end else begin
                check("status_zero_without_done", int'(pkt_status), 0);
            end
            if (fifo_rd_en) last_pop_edge = cyc + 1;
        end
    end

    // Walks the byte stream packet by packet from IDLE and lists what must come out.
    task automatic model_parse(input ent_q_t s, input bit silence);
        int i = 0;
        int n = s.size();
        int len;
        logic [7:0] acc;
        bit abort;
        while (i < n) begin
            if (s[i][FW+1:FW] != 2'b00 || s[i][7:0] != 8'hA5) begin i++; continue; end
            i++;
            if (i >= n) begin if (silence) exp_st.push_back(4); break; end
            if (s[i][FW+1:FW] != 2'b00) begin exp_st.push_back(1); i++; continue; end
            len = int'(s[i][7:0]);
            i++;
            if (len == 0 || len > int'(MAXL)) begin exp_st.push_back(2); continue; end
            acc = len[7:0];
            abort = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (i >= n) begin abort = 1'b1; if (silence) exp_st.push_back(4); break; end
                if (s[i][FW+1:FW] != 2'b00) begin abort = 1'b1; exp_st.push_back(1); i++; break; end
                exp_pl.push_back('{s[i][7:0], k == 0, k == len - 1});
                acc ^= s[i][7:0];
                i++;
            end
            if (abort) continue;
            if (CSUM) begin
                if (i >= n) begin if (silence) exp_st.push_back(4); break; end
                if (s[i][FW+1:FW] != 2'b00) exp_st.push_back(1);
                else exp_st.push_back((s[i][7:0] == acc) ? 0 : 3);
                i++;
            end else begin
                exp_st.push_back(0);
            end
        end
    endtask

    function automatic ent_q_t mk_pkt(input ent_q_t pl);
        ent_q_t r;
        logic [7:0] acc;
        acc = 8'(pl.size());
        r.push_back(10'h0A5);
        r.push_back({2'b00, acc});
        foreach (pl[k]) begin
            r.push_back(pl[k]);
            acc ^= pl[k][7:0];
        end
        if (CSUM) r.push_back({2'b00, acc});
        return r;
    endfunction

    function automatic ent_q_t cat(input ent_q_t a, input ent_q_t b);
        ent_q_t r;
        r = a;
        foreach (b[k]) r.push_back(b[k]);
        return r;
    endfunction

    task automatic clr_got();
        got_pl.delete();
        got_st.delete();
    endtask

    task automatic send(input ent_q_t s, input bit silence, input bit tog);
        model_parse(s, silence);
        toggle_ready = tog;
        @(negedge sys_clk);
        foreach (s[k]) fifo_q.push_back(s[k]);
        for (int t = 0; t < 1000 && !(fifo_q.size() == 0 && fifo_empty); t++) @(negedge sys_clk);
        check("stream_drained", fifo_q.size(), 0);
        toggle_ready = 1'b0;
        repeat (silence ? TMO + 5 : 4) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_q_t s;
        repeat (3) @(negedge sys_clk);
        fifo_q.push_back(10'h0A5);
        repeat (3) @(negedge sys_clk);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        check("rst_pl_valid", int'(pl_valid), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_pkt_status", int'(pkt_status), 0);
        check("rst_busy", int'(busy), 0);
        fifo_q.delete();
        repeat (2) @(negedge sys_clk);
        @(posedge sys_clk); #2 reset = 1'b1;

        // Good packet; trailing 03 is its checksum (dropped in IDLE without the checksum build).
        clr_got();
        s = '{10'h0A5, 10'h003, 10'h011, 10'h022, 10'h033, 10'h003};
        send(s, 1'b0, 1'b0);
        check("t1_count", got_pl.size(), 3);
        check("t1_b0", gp(0), 'h11);
        check("t1_b1", gp(1), 'h22);
        check("t1_b2", gp(2), 'h33);
        check("t1_status", gs(0), 0);
        check("t1_busy", int'(busy), 0);

        clr_got();
        s = cat('{10'h000, 10'h0FF}, mk_pkt('{10'h0AA, 10'h055}));
        send(s, 1'b0, 1'b1);
        check("t2_count", got_pl.size(), 2);
        check("t2_b0", gp(0), 'hAA);
        check("t2_b1", gp(1), 'h55);
        check("t2_status", gs(0), 0);

        clr_got();
        s = cat('{10'h0A5, 10'h000, 10'h0A5, 10'h041}, mk_pkt('{10'h07E}));
        send(s, 1'b0, 1'b0);
        check("t3_st0", gs(0), 2);
        check("t3_st1", gs(1), 2);
        check("t3_st2", gs(2), 0);
        check("t3_b0", gp(0), 'h7E);

        clr_got();
        s = '{10'h0A5, 10'h001, 10'h010, 10'h000};
        send(s, 1'b0, 1'b0);
        check("t4_b0", gp(0), 'h10);
        check("t4_status", gs(0), CSUM ? 3 : 0);

        clr_got();
        s = '{10'h0A5, 10'h003, 10'h021, FE | 10'h042, 10'h063, 10'h0A5, DE | 10'h003};
        s = cat(s, mk_pkt('{10'h001, 10'h002}));
        send(s, 1'b0, 1'b0);
        check("t5_count", got_pl.size(), 3);
        check("t5_b0", gp(0), 'h21);
        check("t5_st0", gs(0), 1);
        check("t5_st1", gs(1), 1);
        check("t5_st2", gs(2), 0);

        clr_got();
        s = '{10'h0A5, 10'h002, 10'h0AB};
        send(s, 1'b1, 1'b0);
        check("t6_b0", gp(0), 'hAB);
        check("t6_status", gs(0), 4);
        check("t6_busy", int'(busy), 0);

        clr_got();
        s = '{10'h0A5, 10'h003, 10'h011};
        send(s, 1'b0, 1'b0);
        check("t7_busy_mid", int'(busy), 1);
        @(posedge sys_clk); #2 reset = 1'b0;
        fifo_q.push_back(10'h011);
        repeat (3) @(negedge sys_clk);
        check("t7_rst_busy", int'(busy), 0);
        check("t7_rst_done", int'(pkt_done), 0);
        check("t7_rst_rd_en", int'(fifo_rd_en), 0);
        check("t7_rst_valid", int'(pl_valid), 0);
        check("t7_rst_data", int'(pl_data), 0);
        @(posedge sys_clk); #2 reset = 1'b1;
        s = mk_pkt('{10'h05A, 10'h0C3});
        send(s, 1'b0, 1'b1);
        check("t7_st_count", got_st.size(), 1);
        check("t7_status", gs(0), 0);
        check("t7_b0", gp(1), 'h5A);
        check("t7_b1", gp(2), 'hC3);

        check("exp_payload_left", exp_pl.size(), 0);
        check("exp_status_left", exp_st.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
